sd_init_sequencer: RTL
======================

Name: sd_init_sequencer

Overview:
- Sequences the SD-card SPI command engine through the SPI-mode initialisation flow: power-up delay, CMD0, CMD8, a CMD55/ACMD41 loop, then CMD58.
- Sits between the top-level card controller and the command engine (spi_cmd_data/spi_cmd/spi_busy/spi_error/spi_response).
- Reports completion, a failure code and the card capacity class.
- It is the only master of the engine until init_done or init_error.

Parameters:
POWERUP_CYCLES, 1000, clk cycles to wait after init_start before CMD0 (>=74 card clocks)
ACMD41_RETRIES, 1000, max CMD55/ACMD41 pairs before giving up
CMD_TIMEOUT, 4096, max clk cycles from spi_cmd pulse to spi_busy falling

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
init_start  in  1  one-cycle pulse; starts the sequence; ignored unless in IDLE, DONE or FAIL
init_busy  out  1  high from accepted init_start until DONE/FAIL
init_done  out  1  level; high in DONE
init_error  out  1  level; high in FAIL
err_code  out  4  failure cause, valid while init_error
card_hc  out  1  CCS bit from CMD58; valid while init_done
spi_cmd_data  out  48  command frame to engine
spi_cmd  out  1  one-cycle issue strobe to engine
spi_busy  in  1  engine busy
spi_error  in  1  engine fault
spi_response  in  48  engine response; R1 is in [47:40]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, res_n). Reset mid-sequence aborts immediately with no cleanup command.
- Reset values: all outputs 0, spi_cmd_data 0, state IDLE.
- Command frames (hex, MSB first):
  - CMD0 = 40_00000000_95
  - CMD8 = 48_000001AA_87
  - CMD55 = 77_00000000_65
  - ACMD41 = 69_40000000_77
  - CMD58 = 7A_00000000_FD
- States: IDLE, POWERUP, ISSUE, WAIT_ACCEPT, WAIT_DONE, CHECK, DONE, FAIL. A register cur_cmd (CMD0/CMD8/CMD55/ACMD41/CMD58) selects the frame and the CHECK rule.
- IDLE/DONE/FAIL + init_start:
  - clear init_done, init_error, err_code, card_hc, retry counter
  - load delay counter with POWERUP_CYCLES; init_busy=1; go to POWERUP.
- POWERUP: decrement each cycle; at 0 set cur_cmd=CMD0 and go to ISSUE.
- ISSUE:
  - wait until spi_busy==0
  - drive spi_cmd_data=frame and spi_cmd=1 for exactly one cycle
  - clear the timeout counter; go to WAIT_ACCEPT.
  - spi_cmd_data holds the frame until the next ISSUE.
- WAIT_ACCEPT: go to WAIT_DONE when spi_busy==1. The engine raises busy the cycle after the strobe.
- WAIT_DONE:
  - when spi_busy==0, sample spi_response and go to CHECK.
  - Timeout and spi_error are checked in both WAIT_ACCEPT and WAIT_DONE:
    - timeout counter reaches CMD_TIMEOUT -> FAIL, code 6
    - spi_error==1 at any time -> FAIL, code 7
    - spi_error wins over timeout in the same cycle.
- CHECK, with r1 = sampled [47:40]:
  - CMD0: r1==01 -> CMD8; else FAIL code 1.
  - CMD8: r1==01, resp[19:16]==1 and resp[15:8]==AA -> CMD55; else FAIL code 2. r1==05 (SDv1/illegal command) is also code 2.
  - CMD55: r1 & FE == 00 -> ACMD41; else FAIL code 3.
  - ACMD41:
    - r1==00 -> CMD58
    - r1==01: increment retry; if retry==ACMD41_RETRIES -> FAIL code 4, else CMD55
    - any other value -> FAIL code 3.
  - CMD58: r1==00 -> card_hc=resp[38] (OCR bit 30); go to DONE. Else FAIL code 5.
- DONE: init_done=1, init_busy=0. FAIL: init_error=1, init_busy=0. Both hold until the next init_start or reset.
- init_start while init_busy is ignored.
- Counters are wide enough for their parameter (clog2+1); no wrap before the limit.

Test Plan:
- Nominal SDHC: model answers CMD0=01, CMD8=01..01AA, ACMD41 01,01,00, CMD58 OCR=C0FF8000 -> issue order CMD0,CMD8,(CMD55,ACMD41)x3,CMD58; init_done=1, card_hc=1, err_code=0.
- Standard capacity: same flow, OCR=80FF8000 -> init_done=1, card_hc=0.
- Failure codes:
  - CMD0 returns FF -> init_error=1, err_code=1, no further spi_cmd.
  - CMD8 returns 05 -> err_code=2.
- Retry exhaustion: ACMD41_RETRIES=3, ACMD41 always 01 -> exactly 3 CMD55/ACMD41 pairs, then err_code=4.
- Engine hang and engine fault:
  - spi_busy stuck 1 with CMD_TIMEOUT=16 -> FAIL err_code=6 at 16 cycles after the strobe.
  - spi_error pulse -> err_code=7.
- Reset during WAIT_DONE of ACMD41 -> all outputs 0 next cycle. A following init_start restarts with POWERUP_CYCLES delay before CMD0.

Source files
------------

// File: rtl/sd_init_sequencer.sv
// SD-card SPI-mode initialisation sequencer: power-up delay, CMD0, CMD8,
// CMD55/ACMD41 polling loop and CMD58, driving a single-command SPI engine.
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES = 1000,
    parameter int ACMD41_RETRIES = 1000,
    parameter int CMD_TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        init_start,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_error,
    output logic [3:0]  err_code,
    output logic        card_hc,
    output logic [47:0] spi_cmd_data,
    output logic        spi_cmd,
    input  logic        spi_busy,
    input  logic        spi_error,
    input  logic [47:0] spi_response,
    output logic [2:0]  dbg_state
);
    localparam int DLY_W = $clog2(POWERUP_CYCLES) + 1;
    localparam int RET_W = $clog2(ACMD41_RETRIES) + 1;
    localparam int TMO_W = $clog2(CMD_TIMEOUT) + 1;
    localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(POWERUP_CYCLES);
    localparam logic [RET_W-1:0] RETRY_LAST = RET_W'(ACMD41_RETRIES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(CMD_TIMEOUT - 1);

    localparam logic [47:0] FRAME_CMD0   = 48'h40_00000000_95;
    localparam logic [47:0] FRAME_CMD8   = 48'h48_000001AA_87;
    localparam logic [47:0] FRAME_CMD55  = 48'h77_00000000_65;
    localparam logic [47:0] FRAME_ACMD41 = 48'h69_40000000_77;
    localparam logic [47:0] FRAME_CMD58  = 48'h7A_00000000_FD;

    typedef enum logic [2:0] {
        S_IDLE, S_POWERUP, S_ISSUE, S_WAIT_ACCEPT,
        S_WAIT_DONE, S_CHECK, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
    } cmd_t;

    state_t           state, state_nxt;
    cmd_t             cur_cmd, cmd_nxt;
    logic [3:0]       fail_code;
    logic             retry_inc;
    logic [47:0]      frame;
    logic [DLY_W-1:0] dly_cnt;
    logic [RET_W-1:0] retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       r1_q;
    logic             ccs_q;
    logic [3:0]       vca_q;
    logic [7:0]       pat_q;
    logic             unused_resp;

    assign unused_resp = ^{spi_response[39], spi_response[37:20], spi_response[7:0]};
    assign dbg_state   = state;

    always_comb begin
        frame = FRAME_CMD0;
        case (cur_cmd)
            C_CMD8:   frame = FRAME_CMD8;
            C_CMD55:  frame = FRAME_CMD55;
            C_ACMD41: frame = FRAME_ACMD41;
            C_CMD58:  frame = FRAME_CMD58;
            default:  frame = FRAME_CMD0;
        endcase
    end

    // Engine handshake: spi_cmd is a one-cycle strobe accepted only while
    // spi_busy is low; the engine raises spi_busy the following cycle and the
    // response is valid on the cycle spi_busy falls again.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cur_cmd;
        fail_code = 4'd0;
        retry_inc = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (init_start) state_nxt = S_POWERUP;
            end
            S_POWERUP: begin
                if (dly_cnt == '0) begin
                    state_nxt = S_ISSUE;
                    cmd_nxt   = C_CMD0;
                end
            end
            S_ISSUE: begin
                if (!spi_busy) state_nxt = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT, S_WAIT_DONE: begin
                if (spi_error) begin
                    state_nxt = S_FAIL;
                    fail_code = 4'd7;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_FAIL;
                    fail_code = 4'd6;
                end else if (state == S_WAIT_ACCEPT && spi_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (state == S_WAIT_DONE && !spi_busy) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_FAIL;
                case (cur_cmd)
                    C_CMD0: begin
                        fail_code = 4'd1;
                        if (r1_q == 8'h01) begin
                            state_nxt = S_ISSUE;
                            cmd_nxt   = C_CMD8;
                        end
                    end
                    C_CMD8: begin
                        fail_code = 4'd2;
                        if (r1_q == 8'h01 && vca_q == 4'h1 && pat_q == 8'hAA) begin
                            state_nxt = S_ISSUE;
                            cmd_nxt   = C_CMD55;
                        end
                    end
                    C_CMD55: begin
                        fail_code = 4'd3;
                        if ((r1_q & 8'hFE) == 8'h00) begin
                            state_nxt = S_ISSUE;
                            cmd_nxt   = C_ACMD41;
                        end
                    end
                    C_ACMD41: begin
                        if (r1_q == 8'h00) begin
                            state_nxt = S_ISSUE;
                            cmd_nxt   = C_CMD58;
                        end else if (r1_q == 8'h01) begin
                            retry_inc = 1'b1;
                            if (retry_cnt == RETRY_LAST) begin
                                fail_code = 4'd4;
                            end else begin
                                state_nxt = S_ISSUE;
                                cmd_nxt   = C_CMD55;
                            end
                        end else begin
                            fail_code = 4'd3;
                        end
                    end
                    default: begin
                        fail_code = 4'd5;
                        if (r1_q == 8'h00) state_nxt = S_DONE;
                    end
                endcase
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= S_IDLE;
            cur_cmd <= C_CMD0;
        end else begin
            state   <= state_nxt;
            cur_cmd <= cmd_nxt;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            init_busy    <= 1'b0;
            init_done    <= 1'b0;
            init_error   <= 1'b0;
            err_code     <= 4'd0;
            card_hc      <= 1'b0;
            spi_cmd_data <= '0;
            spi_cmd      <= 1'b0;
            dly_cnt      <= '0;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
            r1_q         <= '0;
            ccs_q        <= 1'b0;
            vca_q        <= '0;
            pat_q        <= '0;
        end else begin
            spi_cmd <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (init_start) begin
                        init_busy  <= 1'b1;
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        err_code   <= 4'd0;
                        card_hc    <= 1'b0;
                        retry_cnt  <= '0;
                        dly_cnt    <= DLY_LOAD;
                    end
                end
                S_POWERUP: begin
                    if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
                end
                S_ISSUE: begin
                    if (!spi_busy) begin
                        spi_cmd      <= 1'b1;
                        spi_cmd_data <= frame;
                        tmo_cnt      <= '0;
                    end
                end
                S_WAIT_ACCEPT, S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (state == S_WAIT_DONE && !spi_busy) begin
                        r1_q  <= spi_response[47:40];
                        ccs_q <= spi_response[38];
                        vca_q <= spi_response[19:16];
                        pat_q <= spi_response[15:8];
                    end
                end
                S_CHECK: begin
                    if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
                end
                default: ;
            endcase
            // Terminal-state entry: outputs settle together with the state.
            if (state_nxt == S_FAIL && state != S_FAIL) begin
                init_busy  <= 1'b0;
                init_error <= 1'b1;
                err_code   <= fail_code;
            end
            if (state_nxt == S_DONE && state != S_DONE) begin
                init_busy <= 1'b0;
                init_done <= 1'b1;
                card_hc   <= ccs_q;
            end
        end
    end

endmodule
